frac_product_accumulator: RTL
=============================

// Module: frac_product_accumulator
// PURPOSE
//   Downstream stage of the 4-bit fraction multiplier. Consumes its 7-bit two's-complement
//   Product (LSB weight 2^-6) on each Done pulse and sums N products into a saturating
//   accumulator. Presents the frame sum with a one-cycle Res_Valid strobe. Use: dot-product
//   / FIR tap summation.
// PARAMETERS
//   N      8   products per frame (>=2); counter width $clog2(N)
//   ACC_W  9   accumulator/Result width, two's complement, LSB weight 2^-6 (>=7)
// PORTS
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous, active-high reset
//   St         in   1      start/restart frame; 1-cycle pulse
//   Done       in   1      multiplier done; Product valid this cycle
//   Product    in   7      multiplier product, two's complement, 1 sign + 6 fraction bits
//   Result     out  ACC_W  frame sum; valid while Res_Valid=1, held until next report
//   Res_Valid  out  1      1-cycle strobe: Result holds a completed frame
//   Ovf        out  1      frame saturated; registered with Result
//   Busy       out  1      1 in ACCUM and REPORT
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, acc=0, cnt=0, Result=0, Res_Valid=0, Ovf=0, Busy=0.
//   FSM (all transitions on rising CLK):
//     IDLE:   St=1 -> acc=0, cnt=0, sticky ovf=0, go ACCUM. Done ignored; St wins if both.
//     ACCUM:  St=1 -> restart as above; any same-cycle Done product is discarded.
//             else Done=1 -> acc=sat(acc+sext(Product)), cnt++.
//               If cnt was N-1: Result=sat sum, Ovf=sticky|this-add ovf,
//               Res_Valid=1, go REPORT.
//     REPORT: Res_Valid=1 for exactly this cycle. Done ignored.
//             St=1 -> ACCUM (cleared), else IDLE. Res_Valid=0 next cycle.
//   Latency: Res_Valid high in the cycle after the edge that samples the Nth Done.
//   Arithmetic:
//     - Product sign-extended to ACC_W+1 bits; sum in ACC_W+1 bits.
//     - Sum > 2^(ACC_W-1)-1 clamps to max; sum < -2^(ACC_W-1) clamps to min.
//     - Any clamp sets the sticky ovf.
//     - Later adds continue from the clamped value (no wrap-around ever).
//   Busy is combinational from state. Result/Ovf registered, unchanged outside a report.
//   Done held high for multiple cycles counts once per cycle high.
// TESTING
//   1 RST pulse mid-ACCUM after 3 Dones -> all outputs 0 immediately (async),
//     state IDLE, following Dones ignored.
//   2 St, then 8 Dones Product=7'h10 (0.25) -> Result=9'h080 (2.0), Ovf=0,
//     Res_Valid exactly 1 cycle after 8th Done, Busy=0 after.
//   3 St, 8 Dones Product=7'h3F -> saturates at 9'h0FF, Ovf=1;
//     St, 8x 7'h40 (-1.0) -> Result=9'h100, Ovf=1.
//   4 St, 4 Dones 7'h10, St again, 8 Dones 7'h08 -> Result=9'h040
//     (first 4 discarded); St+Done same cycle -> that product not counted.
//   5 Done pulses in IDLE and REPORT -> no effect on acc/cnt;
//     St in REPORT -> Res_Valid still 1 cycle, new frame starts cleared.
//   6 Mixed signs: 4x 7'h20 (+0.5), 4x 7'h70 (-0.25) -> Result=9'h040 (1.0), Ovf=0.

Source files
------------

// File: rtl/frac_product_accumulator.sv
// Sums N fractional products from the multiplier into a saturating accumulator and
// reports each frame sum with a one-cycle Res_Valid strobe.
module frac_product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             St,
  input  logic             Done,
  input  logic [6:0]       Product,
  output logic [ACC_W-1:0] Result,
  output logic             Res_Valid,
  output logic             Ovf,
  output logic             Busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             sticky, sticky_nxt;
  logic [ACC_W-1:0] result_nxt;
  logic             ovf_nxt;
  logic             res_valid_nxt;

  logic [ACC_W:0]   sum;
  logic             clamp_hi, clamp_lo;
  logic [ACC_W-1:0] sat;

  // One guard bit is enough: |acc| <= 2^(ACC_W-1) and |Product| <= 64.
  always_comb begin
    sum      = {acc[ACC_W-1], acc} + {{(ACC_W-6){Product[6]}}, Product};
    clamp_hi = ~sum[ACC_W] &  sum[ACC_W-1];
    clamp_lo =  sum[ACC_W] & ~sum[ACC_W-1];
    if (clamp_hi)      sat = ACC_MAX;
    else if (clamp_lo) sat = ACC_MIN;
    else               sat = sum[ACC_W-1:0];
  end

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    sticky_nxt    = sticky;
    result_nxt    = Result;
    ovf_nxt       = Ovf;
    res_valid_nxt = 1'b0;
    Busy          = (state != IDLE);
    case (state)
      IDLE: begin
        if (St) begin
          acc_nxt    = '0;
          cnt_nxt    = '0;
          sticky_nxt = 1'b0;
          state_nxt  = ACCUM;
        end
      end
      ACCUM: begin
        if (St) begin
          acc_nxt    = '0;
          cnt_nxt    = '0;
          sticky_nxt = 1'b0;
        end else if (Done) begin
          acc_nxt    = sat;
          cnt_nxt    = cnt + CW'(1);
          sticky_nxt = sticky | clamp_hi | clamp_lo;
          if (cnt == LAST) begin
            result_nxt    = sat;
            ovf_nxt       = sticky | clamp_hi | clamp_lo;
            res_valid_nxt = 1'b1;
            state_nxt     = REPORT;
          end
        end
      end
      REPORT: begin
        acc_nxt    = '0;
        cnt_nxt    = '0;
        sticky_nxt = 1'b0;
        state_nxt  = St ? ACCUM : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      Result    <= '0;
      Ovf       <= 1'b0;
      Res_Valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sticky    <= sticky_nxt;
      Result    <= result_nxt;
      Ovf       <= ovf_nxt;
      Res_Valid <= res_valid_nxt;
    end
  end

endmodule
